// File: rtl/my_divider_pkg.sv
// rtl/my_divider_pkg.sv - shared constants, state encoding and sign helpers for my_divider_core
package my_divider_pkg;

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_MAX_WIDTH  = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [DIV_MAX_WIDTH-1:0] DIV_DBZ_QUOT = '1;

    // Helpers work at the widest supported width; callers truncate. Two's
    // complement negation commutes with truncation, so the low bits stay exact.
    function automatic logic [DIV_MAX_WIDTH-1:0] cond_neg(input logic [DIV_MAX_WIDTH-1:0] x,
                                                          input logic en);
        return en ? (~x + {{(DIV_MAX_WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [DIV_MAX_WIDTH-1:0] abs_mag(input logic [DIV_MAX_WIDTH-1:0] x,
                                                         input logic is_signed,
                                                         input logic msb);
        return cond_neg(x, is_signed & msb);
    endfunction

endpackage

// File: rtl/my_divider_core.sv
// rtl/my_divider_core.sv - iterative radix-2 restoring divider, one quotient bit per clock
module my_divider_core
    import my_divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic                  sgn_quo_q, sgn_quo_d;
    logic                  sgn_rem_q, sgn_rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rmd_q, rmd_d;
    logic                  dbz_q, dbz_d;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;

    // dvd_q doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    assign shifted = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sgn_quo_d = signed_mode & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                    sgn_rem_d = signed_mode & dividend[DATA_WIDTH-1];
                    dvd_d     = DATA_WIDTH'(abs_mag(DIV_MAX_WIDTH'(dividend), signed_mode,
                                                    dividend[DATA_WIDTH-1]));
                    dsr_d     = DATA_WIDTH'(abs_mag(DIV_MAX_WIDTH'(divisor), signed_mode,
                                                    divisor[DATA_WIDTH-1]));
                    rem_d     = '0;
                    cnt_d     = CNT_WIDTH'(DATA_WIDTH);
                    if (divisor == '0) begin
                        quo_d   = DATA_WIDTH'(DIV_DBZ_QUOT);
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!trial[DATA_WIDTH]) begin
                    rem_d = trial[DATA_WIDTH-1:0];
                end else begin
                    rem_d = shifted[DATA_WIDTH-1:0];
                end
                dvd_d = {dvd_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quo_d   = DATA_WIDTH'(cond_neg(DIV_MAX_WIDTH'(dvd_q), sgn_quo_q));
                rmd_d   = DATA_WIDTH'(cond_neg(DIV_MAX_WIDTH'(rem_q), sgn_rem_q));
                dbz_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_my_divider_core.sv
// tb/tb_my_divider_core.sv - scoreboard bench for my_divider_core with an arithmetic reference model
module tb_my_divider_core;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    my_divider_core dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          k0;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference: plain integer division on wide signed arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         output exp_t e);
        longint sa, sb;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
            e.lat = 1;
        end else begin
            if (sm) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                e.q = 32'(sa / sb);
                e.r = 32'(sa % sb);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
            e.z = 1'b0;
            e.lat = 34;
        end
    endtask

    always @(negedge ACLK) begin
        if (ARESETN && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                chk("latency", 32'(cyc - e.k0 + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy && !done) return;
            @(negedge ACLK);
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: got busy=%0b done=%0b want idle within 200 cycles", busy, done);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic sm,
                            input int k0);
        exp_t e;
        model(a, b, sm, e);
        e.k0 = k0;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm);
        wait_idle();
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        push_exp(a, b, sm, cyc + 1);
        @(negedge ACLK);
        start       = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        signed_mode = 1'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        sm;
        int          sel;

        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        issue(32'd100, 32'd7, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        issue(32'h1234_5678, 32'd0, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b1);
        issue(32'd9, 32'd4, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);

        // start held high: second operation accepted right after DONE
        wait_idle();
        dividend = 32'd12345; divisor = 32'd17; signed_mode = 1'b0; start = 1'b1;
        push_exp(32'd12345, 32'd17, 1'b0, cyc + 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (done) break;
        end
        dividend = 32'hFFFF_0000; divisor = 32'd3; signed_mode = 1'b1;
        push_exp(32'hFFFF_0000, 32'd3, 1'b1, cyc + 2);
        repeat (2) @(negedge ACLK);
        start = 1'b0;

        // start during a busy operation is ignored
        issue(32'd1000, 32'd10, 1'b0);
        repeat (8) @(negedge ACLK);
        dividend = 32'd5; divisor = 32'd1; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;

        // reset mid-operation
        issue(32'd50, 32'd3, 1'b0);
        repeat (13) @(negedge ACLK);
        chk("busy_mid_op", {31'd0, busy}, 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (5) @(negedge ACLK);
        issue(32'd50, 32'd3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            a = $urandom;
            if (sel == 9) a = 32'h8000_0000;
            if (sel == 0) b = 32'd0;
            else if (sel < 4) b = 32'($urandom_range(1, 20));
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else b = $urandom;
            sm = 1'($urandom);
            issue(a, b, sm);
        end

        wait_idle();
        @(negedge ACLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
